demux1to2_16b_buf: RTL and testbench
====================================

DEMUX1TO2_16B_BUF -- requirements
Module: demux1to2_16b_buf

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning per-port FIFO entries (power of two, >=2).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning width of the per-port routed-word counters.
REQ-003 The block SHALL use one clock, clkpos, and a synchronous active-high reset, rst; all state updates on the rising edge of clkpos.
REQ-004 Port: clkpos  input  1  clock.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: vdd, vss  input  1 each  supply ties; no logical function; bench drives 1 and 0.
REQ-007 Port: din  input  16  word to be steered.
REQ-008 Port: din_valid  input  1  din holds a valid word.
REQ-009 Port: din_ready  output  1  block can accept a word for the port currently selected by sel.
REQ-010 Port: sel  input  1  destination select: 0 selects port a, 1 selects port b; sampled with din.
REQ-011 Port: a, b  output  16 each  head word of the port-a and port-b FIFO.
REQ-012 Port: a_valid, b_valid  output  1 each  the matching FIFO is non-empty.
REQ-013 Port: a_ready, b_ready  input  1 each  downstream consumes the head word.
REQ-014 Port: cnt_a, cnt_b  output  CNT_W each  words accepted into each port since reset.

Function
REQ-015 An input handshake SHALL occur on a clkpos edge where din_valid=1, din_ready=1 and rst=0.
REQ-016 din_ready SHALL equal NOT full of the FIFO selected by sel, and SHALL be 0 while rst=1.
REQ-017 din_ready SHALL have no combinational dependence on a_ready or b_ready; a full FIFO refuses input even when it is popped in the same cycle.
REQ-018 On a handshake, din SHALL be written to the tail of the selected FIFO only; the other FIFO SHALL be unchanged.
REQ-019 Latency SHALL be one cycle: a word accepted at edge N is visible on a/a_valid (or b/b_valid) after edge N when its FIFO was empty.
REQ-020 An output pop SHALL occur on an edge where x_valid=1 and x_ready=1, removing the head word; x_ready while x_valid=0 SHALL have no effect.
REQ-021 Each FIFO SHALL preserve arrival order; ports a and b are independent and may pop in the same cycle.
REQ-022 A simultaneous push and pop on the same non-full FIFO SHALL leave its occupancy unchanged and keep the order.
REQ-023 a and b SHALL drive 16'h0000 whenever the matching valid is 0.
REQ-024 cnt_a or cnt_b SHALL increment by 1 on each handshake into that port and wrap from 2^CNT_W-1 to 0.
REQ-025 Occupancy SHALL never exceed DEPTH and never underflow. Read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-026 While rst=1 at an edge, both FIFOs SHALL be emptied, a_valid=b_valid=0, a=b=16'h0000, cnt_a=cnt_b=0. Any concurrent handshake or pop SHALL be ignored.
REQ-027 Reset asserted mid-operation SHALL discard all buffered words. The first edge with rst=0 SHALL behave as from power-up, with din_ready=1.

Verification
REQ-028 Reset: rst=1 for 2 cycles, then release -> a_valid=b_valid=0, a=b=0, cnt_a=cnt_b=0, din_ready=1.
REQ-029 Route: sel=0, din=16'hA5A5, din_valid=1 for one cycle -> next cycle a_valid=1, a=16'hA5A5, b_valid=0, cnt_a=1. Repeat with sel=1, din=16'h5A5A -> b=16'h5A5A, cnt_b=1.
REQ-030 Backpressure: a_ready=0; push 16'h0001, 16'h0002, 16'h0003 with sel=0 -> first two accepted, din_ready=0 on the third. Switch sel=1 -> din_ready=1. Raise a_ready -> a shows 0001 then 0002, then a_valid=0.
REQ-031 Push/pop same cycle: port a holds one word, a_ready=1, push 16'h00FF with sel=0 -> occupancy stays 1 and a=16'h00FF next cycle. Full FIFO plus a_ready=1 -> din_ready stays 0 that cycle.
REQ-032 Counter wrap: push 256 words to port b with b_ready=1 (CNT_W=8) -> cnt_b=0, cnt_a unchanged.
REQ-033 Reset mid-operation: both FIFOs full, rst=1 for one cycle -> a_valid=b_valid=0 and counters 0 next cycle. A subsequent push of 16'hBEEF to a appears alone at the head.

Source files
------------

// File: rtl/demux1to2_16b_buf.sv
// rtl/demux1to2_16b_buf.sv - 1-to-2 demultiplexer with a buffered FIFO per output port

module demux1to2_16b_buf_fifo #(
    parameter int DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_push,
    input  logic [15:0] i_data,
    input  logic        i_ready,
    output logic [15:0] o_data,
    output logic        o_valid,
    output logic        o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_wr;

    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == FULL_CNT);
    // Push is qualified by the caller; guard against a full FIFO regardless.
    assign w_wr    = i_push & ~o_full;
    assign w_pop   = o_valid & i_ready;
    assign o_data  = o_valid ? r_mem[r_rptr] : 16'h0000;

    // Storage write; contents need no reset because the output is gated by valid.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_wr) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); occupancy tracks push minus pop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};
        end
    end
endmodule

module demux1to2_16b_buf #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clkpos,
    input  logic             rst,
    input  logic             vdd,
    input  logic             vss,
    input  logic [15:0]      din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             sel,
    output logic [15:0]      a,
    output logic [15:0]      b,
    output logic             a_valid,
    output logic             b_valid,
    input  logic             a_ready,
    input  logic             b_ready,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);
    logic             w_full_a;
    logic             w_full_b;
    logic             w_push_a;
    logic             w_push_b;
    logic             w_unused_supply;
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;

    // Supply ties carry no logic.
    assign w_unused_supply = vdd ^ vss;

    // Ready looks only at the selected FIFO's full flag, never at downstream ready.
    assign din_ready = ~rst & ~(sel ? w_full_b : w_full_a);
    assign w_push_a  = din_valid & din_ready & ~sel;
    assign w_push_b  = din_valid & din_ready &  sel;

    demux1to2_16b_buf_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .i_clk   (clkpos),
        .i_rst   (rst),
        .i_push  (w_push_a),
        .i_data  (din),
        .i_ready (a_ready),
        .o_data  (a),
        .o_valid (a_valid),
        .o_full  (w_full_a)
    );

    demux1to2_16b_buf_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .i_clk   (clkpos),
        .i_rst   (rst),
        .i_push  (w_push_b),
        .i_data  (din),
        .i_ready (b_ready),
        .o_data  (b),
        .o_valid (b_valid),
        .o_full  (w_full_b)
    );

    // Per-port accepted-word counters, wrapping at 2^CNT_W.
    always_ff @(posedge clkpos) begin
        if (rst) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            if (w_push_a) begin
                r_cnt_a <= r_cnt_a + 1'b1;
            end
            if (w_push_b) begin
                r_cnt_b <= r_cnt_b + 1'b1;
            end
        end
    end

    assign cnt_a = r_cnt_a;
    assign cnt_b = r_cnt_b;
endmodule

// File: tb/tb_demux1to2_16b_buf.sv
// tb/tb_demux1to2_16b_buf.sv - self-checking bench for demux1to2_16b_buf

module tb_demux1to2_16b_buf;
    localparam int DEPTH = 2;
    localparam int CNT_W = 8;

    logic             clkpos = 1'b0;
    logic             rst = 1'b1;
    logic             vdd = 1'b1;
    logic             vss = 1'b0;
    logic [15:0]      din = 16'h0000;
    logic             din_valid = 1'b0;
    logic             din_ready;
    logic             sel = 1'b0;
    logic [15:0]      a;
    logic [15:0]      b;
    logic             a_valid;
    logic             b_valid;
    logic             a_ready = 1'b0;
    logic             b_ready = 1'b0;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    int tests = 0;
    int fails = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    int          ca = 0;
    int          cb = 0;

    demux1to2_16b_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clkpos    (clkpos),
        .rst       (rst),
        .vdd       (vdd),
        .vss       (vss),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .sel       (sel),
        .a         (a),
        .b         (b),
        .a_valid   (a_valid),
        .b_valid   (b_valid),
        .a_ready   (a_ready),
        .b_ready   (b_ready),
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b)
    );

    always #5 clkpos = ~clkpos;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: advance the queue model by one edge using the current inputs, then clock.
    task automatic tick();
        bit hs;
        bit pa;
        bit pb;
        if (rst) begin
            qa.delete();
            qb.delete();
            ca = 0;
            cb = 0;
        end else begin
            hs = din_valid && (sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
            pa = a_ready && (qa.size() > 0);
            pb = b_ready && (qb.size() > 0);
            if (pa) void'(qa.pop_front());
            if (pb) void'(qb.pop_front());
            if (hs) begin
                if (sel) begin
                    qb.push_back(din);
                    cb = (cb + 1) % (1 << CNT_W);
                end else begin
                    qa.push_back(din);
                    ca = (ca + 1) % (1 << CNT_W);
                end
            end
        end
        @(posedge clkpos);
        #1;
    endtask

    task automatic check_all(input string tag);
        logic exp_rdy;
        exp_rdy = !rst && (sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
        chk({tag, ".din_ready"}, {31'd0, din_ready}, {31'd0, exp_rdy});
        chk({tag, ".a_valid"}, {31'd0, a_valid}, {31'd0, qa.size() > 0});
        chk({tag, ".b_valid"}, {31'd0, b_valid}, {31'd0, qb.size() > 0});
        chk({tag, ".a"}, {16'd0, a}, {16'd0, (qa.size() > 0) ? qa[0] : 16'h0000});
        chk({tag, ".b"}, {16'd0, b}, {16'd0, (qb.size() > 0) ? qb[0] : 16'h0000});
        chk({tag, ".cnt_a"}, 32'(cnt_a), 32'(ca));
        chk({tag, ".cnt_b"}, 32'(cnt_b), 32'(cb));
    endtask

    initial begin
        int ca0;

        // Reset for two cycles then release.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst.a_valid", {31'd0, a_valid}, 32'd0);
        chk("rst.b_valid", {31'd0, b_valid}, 32'd0);
        chk("rst.a", {16'd0, a}, 32'd0);
        chk("rst.b", {16'd0, b}, 32'd0);
        chk("rst.cnt_a", 32'(cnt_a), 32'd0);
        chk("rst.cnt_b", 32'(cnt_b), 32'd0);
        chk("rst.din_ready", {31'd0, din_ready}, 32'd1);

        // Basic routing to each port.
        sel = 1'b0; din = 16'hA5A5; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        chk("route_a.a_valid", {31'd0, a_valid}, 32'd1);
        chk("route_a.a", {16'd0, a}, 32'h0000A5A5);
        chk("route_a.b_valid", {31'd0, b_valid}, 32'd0);
        chk("route_a.cnt_a", 32'(cnt_a), 32'd1);
        sel = 1'b1; din = 16'h5A5A; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        chk("route_b.b", {16'd0, b}, 32'h00005A5A);
        chk("route_b.cnt_b", 32'(cnt_b), 32'd1);
        check_all("route");
        a_ready = 1'b1; b_ready = 1'b1;
        tick();
        a_ready = 1'b0; b_ready = 1'b0;
        check_all("drain1");

        // Backpressure on port a.
        sel = 1'b0; din_valid = 1'b1;
        din = 16'h0001; tick();
        din = 16'h0002; tick();
        din = 16'h0003; #1;
        chk("bp.full_ready", {31'd0, din_ready}, 32'd0);
        tick();
        sel = 1'b1; #1;
        chk("bp.other_ready", {31'd0, din_ready}, 32'd1);
        din_valid = 1'b0; sel = 1'b0;
        a_ready = 1'b1; #1;
        chk("bp.head1", {16'd0, a}, 32'h00000001);
        tick();
        chk("bp.head2", {16'd0, a}, 32'h00000002);
        tick();
        chk("bp.empty", {31'd0, a_valid}, 32'd0);
        a_ready = 1'b0;
        check_all("bp");

        // Simultaneous push and pop on port a.
        din = 16'h0010; din_valid = 1'b1; tick();
        a_ready = 1'b1; din = 16'h00FF; tick();
        din_valid = 1'b0; a_ready = 1'b0;
        chk("pp.a", {16'd0, a}, 32'h000000FF);
        chk("pp.a_valid", {31'd0, a_valid}, 32'd1);
        check_all("pp");
        din = 16'h0020; din_valid = 1'b1; tick();
        a_ready = 1'b1; din = 16'h0030; #1;
        chk("pp.full_pop_ready", {31'd0, din_ready}, 32'd0);
        tick();
        check_all("pp_full");
        din_valid = 1'b0;
        tick(); tick();
        a_ready = 1'b0;
        check_all("pp_drain");

        // Counter wrap on port b after a fresh reset.
        rst = 1'b1; tick(); rst = 1'b0;
        sel = 1'b0; din = 16'h1234; din_valid = 1'b1; tick();
        ca0 = ca;
        sel = 1'b1; b_ready = 1'b1; a_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            din = 16'($urandom);
            tick();
        end
        din_valid = 1'b0;
        chk("wrap.cnt_b", 32'(cnt_b), 32'd0);
        chk("wrap.cnt_a", 32'(cnt_a), 32'(ca0));
        tick();
        b_ready = 1'b0;
        check_all("wrap");

        // Reset with both FIFOs full.
        din_valid = 1'b1;
        sel = 1'b0; din = 16'h0A0A; tick(); tick();
        sel = 1'b1; din = 16'h0B0B; tick(); tick();
        chk("rstmid.a_full", {31'd0, a_valid}, 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        din_valid = 1'b0;
        chk("rstmid.a_valid", {31'd0, a_valid}, 32'd0);
        chk("rstmid.b_valid", {31'd0, b_valid}, 32'd0);
        chk("rstmid.cnt_a", 32'(cnt_a), 32'd0);
        chk("rstmid.cnt_b", 32'(cnt_b), 32'd0);
        sel = 1'b0; din = 16'hBEEF; din_valid = 1'b1; tick();
        din_valid = 1'b0;
        chk("rstmid.beef", {16'd0, a}, 32'h0000BEEF);
        a_ready = 1'b1; tick(); a_ready = 1'b0;
        chk("rstmid.alone", {31'd0, a_valid}, 32'd0);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            din       = 16'($urandom);
            din_valid = 1'($urandom_range(0, 3) != 0);
            sel       = 1'($urandom);
            a_ready   = 1'($urandom_range(0, 2) == 0);
            b_ready   = 1'($urandom_range(0, 2) == 0);
            rst       = 1'($urandom_range(0, 39) == 0);
            #1;
            check_all("rand_pre");
            tick();
            rst = 1'b0;
            #1;
            check_all("rand_post");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
